// File: rtl/avmm_bridge_pkg.sv
// Shared types and default widths for the accelerator-to-SDRAM pipeline bridge.
package avmm_bridge_pkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int MAX_PENDING = 4;

  typedef struct packed {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } bridge_cmd_t;

endpackage

// File: rtl/avmm_sdram_bridge_pending_counter.sv
// Outstanding-read counter: +1 on read issue, -1 on returned data, never below zero.
module pending_counter #(
  parameter  int MAX = 4,
  localparam int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          at_max,
  output logic          zero,
  output logic          underflow
);

  logic dec_ok;

  assign zero      = (count == '0);
  assign at_max    = (count == CW'(MAX));
  assign underflow = dec & zero;
  // A return with nothing outstanding is spurious and must not wrap the count.
  assign dec_ok    = dec & ~zero;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec_ok) begin
      count <= count + CW'(1);
    end else if (!inc && dec_ok) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/avmm_sdram_bridge.sv
// Single-entry command stage with read-before-write ordering between the copy accelerator and SDRAM.
module avmm_sdram_bridge
  import avmm_bridge_pkg::*;
#(
  parameter int ADDR_W      = avmm_bridge_pkg::ADDR_W,
  parameter int DATA_W      = avmm_bridge_pkg::DATA_W,
  parameter int MAX_PENDING = avmm_bridge_pkg::MAX_PENDING
) (
  input  logic              clk,
  input  logic              rst,
  output logic              s_waitrequest,
  input  logic [ADDR_W-1:0] s_address,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [DATA_W-1:0] s_writedata,
  output logic [DATA_W-1:0] s_readdata,
  output logic              s_readdatavalid,
  input  logic              m_waitrequest,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  output logic              err
);

  localparam int CW = $clog2(MAX_PENDING + 1);

  bridge_cmd_t   cmd;
  logic          cmd_valid;
  logic          cmd_done;
  logic [CW-1:0] pending;
  logic          at_max;
  logic          zero;
  logic          underflow;

  pending_counter #(.MAX(MAX_PENDING)) u_pending (
    .clk       (clk),
    .rst       (rst),
    .inc       (m_read & ~m_waitrequest),
    .dec       (m_readdatavalid),
    .count     (pending),
    .at_max    (at_max),
    .zero      (zero),
    .underflow (underflow)
  );

  assign s_waitrequest = rst | cmd_valid;
  // Writes wait for every earlier read so overlapping copies read before they overwrite.
  assign m_read        = cmd_valid & ~cmd.is_wr & ~at_max;
  assign m_write       = cmd_valid &  cmd.is_wr &  zero;
  assign m_address     = cmd.addr;
  assign m_writedata   = cmd.data;
  assign cmd_done      = (m_read | m_write) & ~m_waitrequest;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid       <= 1'b0;
      cmd             <= '0;
      err             <= 1'b0;
      s_readdatavalid <= 1'b0;
      s_readdata      <= '0;
    end else begin
      if (cmd_valid) begin
        if (cmd_done) cmd_valid <= 1'b0;
      end else if (s_read || s_write) begin
        cmd_valid <= 1'b1;
        cmd       <= '{is_wr: s_write, addr: s_address, data: s_writedata};
      end
      // Simultaneous read+write is taken as the write; both it and spurious data are sticky errors.
      if ((!cmd_valid && s_read && s_write) || underflow) err <= 1'b1;
      s_readdatavalid <= m_readdatavalid & (pending != '0);
      s_readdata      <= m_readdata;
    end
  end

endmodule

// File: tb/tb_avmm_sdram_bridge.sv
// Directed bench for avmm_sdram_bridge: a cycle table plus hand-written multi-cycle sequences.
module tb_avmm_sdram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_waitrequest;
  logic [31:0] s_address;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;
  logic        m_waitrequest;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  avmm_sdram_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .s_waitrequest   (s_waitrequest),
    .s_address       (s_address),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .m_waitrequest   (m_waitrequest),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .err             (err)
  );

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic        mwait, mrdv;
    logic [31:0] mrdata;
    logic        e_swait, e_mread, e_mwrite;
    logic [31:0] e_maddr, e_mwdata;
    logic        e_srdv;
    logic [31:0] e_srdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                              logic mwait, logic mrdv, logic [31:0] mrdata,
                              logic e_swait, logic e_mread, logic e_mwrite,
                              logic [31:0] e_maddr, logic [31:0] e_mwdata,
                              logic e_srdv, logic [31:0] e_srdata, logic e_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.mwait = mwait; v.mrdv = mrdv; v.mrdata = mrdata;
    v.e_swait = e_swait; v.e_mread = e_mread; v.e_mwrite = e_mwrite;
    v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
    v.e_srdv = e_srdv; v.e_srdata = e_srdata; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic mwait, input logic mrdv,
                       input logic [31:0] mrdata);
    s_read = rd; s_write = wr; s_address = addr; s_writedata = wdata;
    m_waitrequest = mwait; m_readdatavalid = mrdv; m_readdata = mrdata;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic issue_read(input logic [31:0] addr);
    cyc(); drive(1'b1, 1'b0, addr, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(); idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();

    // Single read, 3-cycle SDRAM latency.
    vecs.push_back(mk(1,0,32'h100,0, 0,0,0,          0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,          1,1,0,32'h100,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,          0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,          0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,       0,1,32'hDEADBEEF, 0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,          0,0,0,0,0, 1,32'hDEADBEEF,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,          0,0,0,0,0, 0,0,0));
    // Write behind two pending reads.
    vecs.push_back(mk(1,0,32'h300,0, 0,0,0,          0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,          1,1,0,32'h300,0, 0,0,0));
    vecs.push_back(mk(1,0,32'h304,0, 0,0,0,          0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,          1,1,0,32'h304,0, 0,0,0));
    vecs.push_back(mk(0,1,32'h200,32'h55AA55AA, 0,0,0, 0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,       0,1,32'h11111111, 1,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,          1,0,0,0,0, 1,32'h11111111,0));
    vecs.push_back(mk(0,0,0,0,       0,1,32'h22222222, 1,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,          1,0,1,32'h200,32'h55AA55AA, 1,32'h22222222,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,          0,0,0,0,0, 0,0,0));

    // Reset state.
    cyc();
    @(negedge clk);
    check("rst_swait", 32'(s_waitrequest), 32'h1);
    cyc(); rst = 1'b0;
    @(negedge clk);
    check("rst_swait_low", 32'(s_waitrequest), 32'h0);
    check("rst_mread",     32'(m_read), 32'h0);
    check("rst_mwrite",    32'(m_write), 32'h0);
    check("rst_maddr",     m_address, 32'h0);
    check("rst_mwdata",    m_writedata, 32'h0);
    check("rst_srdv",      32'(s_readdatavalid), 32'h0);
    check("rst_srdata",    s_readdata, 32'h0);
    check("rst_err",       32'(err), 32'h0);

    foreach (vecs[i]) begin
      cyc();
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
            vecs[i].mwait, vecs[i].mrdv, vecs[i].mrdata);
      @(negedge clk);
      check($sformatf("v%0d swait", i),  32'(s_waitrequest), 32'(vecs[i].e_swait));
      check($sformatf("v%0d mread", i),  32'(m_read), 32'(vecs[i].e_mread));
      check($sformatf("v%0d mwrite", i), 32'(m_write), 32'(vecs[i].e_mwrite));
      check($sformatf("v%0d srdv", i),   32'(s_readdatavalid), 32'(vecs[i].e_srdv));
      check($sformatf("v%0d err", i),    32'(err), 32'(vecs[i].e_err));
      if (vecs[i].e_mread || vecs[i].e_mwrite)
        check($sformatf("v%0d maddr", i), m_address, vecs[i].e_maddr);
      if (vecs[i].e_mwrite)
        check($sformatf("v%0d mwdata", i), m_writedata, vecs[i].e_mwdata);
      if (vecs[i].e_srdv)
        check($sformatf("v%0d srdata", i), s_readdata, vecs[i].e_srdata);
    end

    // Five reads with no responses: only MAX_PENDING reach SDRAM.
    for (int i = 0; i < 4; i++) begin
      cyc(); drive(1'b1, 1'b0, 32'h400 + 32'(4 * i), 32'h0, 1'b0, 1'b0, 32'h0);
      @(negedge clk); check($sformatf("rd%0d_accept", i), 32'(s_waitrequest), 32'h0);
      cyc(); idle();
      @(negedge clk); check($sformatf("rd%0d_issue", i), 32'(m_read), 32'h1);
      check($sformatf("rd%0d_addr", i), m_address, 32'h400 + 32'(4 * i));
    end
    cyc(); drive(1'b1, 1'b0, 32'h410, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); check("rd4_accept", 32'(s_waitrequest), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(); idle();
      @(negedge clk);
      check($sformatf("rd4_held_mread%0d", k), 32'(m_read), 32'h0);
      check($sformatf("rd4_held_swait%0d", k), 32'(s_waitrequest), 32'h1);
    end
    cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0001);
    @(negedge clk); check("rd4_still_held", 32'(m_read), 32'h0);
    cyc(); idle();
    @(negedge clk);
    check("rd4_released", 32'(m_read), 32'h1);
    check("rd4_addr", m_address, 32'h410);
    check("rd4_resp_srdv", 32'(s_readdatavalid), 32'h1);
    check("rd4_resp_data", s_readdata, 32'h0000_0001);
    cyc(); idle();
    @(negedge clk); check("rd4_done_swait", 32'(s_waitrequest), 32'h0);
    for (int j = 0; j < 4; j++) begin
      cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10 + 32'(j));
    end
    cyc(); idle();
    @(negedge clk);
    check("drain_srdv", 32'(s_readdatavalid), 32'h1);
    check("drain_data", s_readdata, 32'h13);
    check("drain_err", 32'(err), 32'h0);

    // Write stalled by m_waitrequest for three cycles.
    cyc(); drive(1'b0, 1'b1, 32'h500, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0);
    @(negedge clk); check("wws_accept", 32'(s_waitrequest), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      check($sformatf("wws_mwrite%0d", k), 32'(m_write), 32'h1);
      check($sformatf("wws_addr%0d", k), m_address, 32'h500);
      check($sformatf("wws_data%0d", k), m_writedata, 32'hCAFEF00D);
      check($sformatf("wws_swait%0d", k), 32'(s_waitrequest), 32'h1);
    end
    cyc(); idle();
    @(negedge clk); check("wws_go", 32'(m_write), 32'h1);
    cyc(); idle();
    @(negedge clk);
    check("wws_cleared_mwrite", 32'(m_write), 32'h0);
    check("wws_cleared_swait", 32'(s_waitrequest), 32'h0);

    // Same-cycle issue and return at pending 2, then a spurious return.
    issue_read(32'h600);
    issue_read(32'h604);
    cyc(); drive(1'b1, 1'b0, 32'h608, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); check("same_accept", 32'(s_waitrequest), 32'h0);
    cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA1);
    @(negedge clk); check("same_mread", 32'(m_read), 32'h1);
    cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA2);
    @(negedge clk); check("same_r1", s_readdata & {32{s_readdatavalid}}, 32'hA1);
    cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA3);
    @(negedge clk); check("same_r2", s_readdata & {32{s_readdatavalid}}, 32'hA2);
    cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hBAD);
    @(negedge clk);
    check("same_r3", s_readdata & {32{s_readdatavalid}}, 32'hA3);
    check("same_err_before", 32'(err), 32'h0);
    cyc(); idle();
    @(negedge clk);
    check("spurious_srdv", 32'(s_readdatavalid), 32'h0);
    check("spurious_err", 32'(err), 32'h1);
    repeat (3) cyc();
    @(negedge clk); check("err_sticky", 32'(err), 32'h1);

    // Reset mid-operation with reads pending and a write held in the stage.
    issue_read(32'h700);
    issue_read(32'h704);
    issue_read(32'h708);
    cyc(); drive(1'b0, 1'b1, 32'h720, 32'h12345678, 1'b0, 1'b0, 32'h0);
    @(negedge clk); check("mid_accept", 32'(s_waitrequest), 32'h0);
    cyc(); idle();
    @(negedge clk);
    check("mid_held_mwrite", 32'(m_write), 32'h0);
    check("mid_held_swait", 32'(s_waitrequest), 32'h1);
    cyc(); rst = 1'b1;
    @(negedge clk); check("mid_rst_swait", 32'(s_waitrequest), 32'h1);
    cyc(); rst = 1'b0;
    drive(1'b0, 1'b1, 32'h730, 32'h0BADF00D, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("post_rst_swait",  32'(s_waitrequest), 32'h0);
    check("post_rst_mread",  32'(m_read), 32'h0);
    check("post_rst_mwrite", 32'(m_write), 32'h0);
    check("post_rst_maddr",  m_address, 32'h0);
    check("post_rst_mwdata", m_writedata, 32'h0);
    check("post_rst_srdv",   32'(s_readdatavalid), 32'h0);
    check("post_rst_srdata", s_readdata, 32'h0);
    check("post_rst_err",    32'(err), 32'h0);
    cyc(); idle();
    @(negedge clk);
    check("post_rst_wr_go",   32'(m_write), 32'h1);
    check("post_rst_wr_addr", m_address, 32'h730);
    check("post_rst_wr_data", m_writedata, 32'h0BADF00D);
    cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h700);
    @(negedge clk); check("stale_swait", 32'(s_waitrequest), 32'h0);
    cyc(); idle();
    @(negedge clk);
    check("stale_srdv", 32'(s_readdatavalid), 32'h0);
    check("stale_err", 32'(err), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
